// File: rtl/riscv_pkg.sv
// Shared RV32 constants: NOP encoding, fetch FSM states, opcodes and the fetch queue entry.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fq_entry_t;
endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bundle: instruction memory req/gnt/rvalid, redirect input and decode handshake.
// FETCH_PERF_CNT_EN adds the perf_fetched / perf_stall counter outputs.
interface inst_fetch_unit_if;
    import riscv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic [XLEN-1:0] if_inst;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]     perf_fetched;
    logic [31:0]     perf_stall;
`endif

    modport master (
        output imem_req, imem_addr, if_valid, if_inst, if_pc,
`ifdef FETCH_PERF_CNT_EN
        output perf_fetched, perf_stall,
`endif
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_inst, if_pc,
`ifdef FETCH_PERF_CNT_EN
        input  perf_fetched, perf_stall,
`endif
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, inst} entries; flush empties it, push+pop allowed when full.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fq_entry_t              push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fq_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    fq_entry_t        mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset: an entry is only read once count says it was written.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, request credits, stale-response discard and fetch FSM.
// Optional FETCH_PERF_CNT_EN adds transfer and decode-starvation counters.
module inst_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 4
) (
    input logic               clk,
    input logic               rst_n,
    inst_fetch_unit_if.master bus
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [1:0]      state;
    logic [XLEN-1:0] fetch_pc, resp_pc, redir_tgt;
    logic [CW-1:0]   outst, discard, q_count, outst_nxt, count_nxt;
    logic            issue, xfer, accept, q_full, q_empty;
    fq_entry_t       q_head;

    assign redir_tgt = bus.redirect_pc & 32'hFFFF_FFFC;
    assign bus.imem_req  = (state == S_RUN) & ~bus.redirect_valid;
    assign bus.imem_addr = fetch_pc;
    assign issue  = bus.imem_req & bus.imem_gnt;
    assign xfer   = bus.if_valid & bus.id_ready;
    assign accept = bus.imem_rvalid & (discard == '0) & ~bus.redirect_valid;

    assign bus.if_valid = ~q_empty;
    assign bus.if_inst  = q_empty ? NOP_INST : q_head.inst;
    assign bus.if_pc    = q_empty ? '0 : q_head.pc;

    // Credit counts queue slots plus in-flight reads, so every response has a slot.
    assign outst_nxt = outst + CW'(issue) - CW'(bus.imem_rvalid);
    assign count_nxt = bus.redirect_valid ? '0 : (q_count + CW'(accept) - CW'(xfer));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_BOOT;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            outst    <= '0;
            discard  <= '0;
        end else begin
            outst <= outst_nxt;
            if (state == S_BOOT)
                state <= S_RUN;
            else
                state <= ((int'(count_nxt) + int'(outst_nxt)) >= QDEPTH) ? S_FULL : S_RUN;
            if (bus.redirect_valid) begin
                fetch_pc <= redir_tgt;
                resp_pc  <= redir_tgt;
                discard  <= outst - CW'(bus.imem_rvalid);
            end else begin
                if (issue)  fetch_pc <= fetch_pc + 32'd4;
                if (accept) resp_pc  <= resp_pc + 32'd4;
                if (bus.imem_rvalid && discard != '0) discard <= discard - 1'b1;
            end
        end
    end

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data ({resp_pc, bus.imem_rdata}),
        .pop       (xfer),
        .flush     (bus.redirect_valid),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(q_full && accept && !xfer));

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (xfer) perf_fetched <= perf_fetched + 32'd1;
            if (bus.id_ready && !bus.if_valid && state != S_BOOT) perf_stall <= perf_stall + 32'd1;
        end
    end

    assign bus.perf_fetched = perf_fetched;
    assign bus.perf_stall   = perf_stall;
`endif
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: in-order memory model, directed phases then random traffic.
module tb_inst_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          QD     = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    inst_fetch_unit_if bus();

    inst_fetch_unit #(.RESET_PC(RST_PC), .QDEPTH(QD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;

    int checks = 0, errors = 0;
    int phase = 0, cyc = 0, last_due = 0;
    int gnt_pct = 100, lat_min = 1, lat_max = 1;
    mreq_t pend[$];

    // Monitor-owned model state (read-only for the driver).
    logic [31:0] exp_q[$];
    logic [31:0] nxt_pc, fetch_exp, post_tgt, e;
    logic        post_redir;
    int          k, inflight, iss_cnt, xfer_cnt, first_valid_k;
    logic [31:0] m_fetched, m_stall;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Drive this cycle's inputs, record any issued request, then present due responses.
    task automatic step(logic ready, logic redir, logic [31:0] tgt);
        bus.imem_gnt       = ($urandom_range(99, 0) < gnt_pct);
        bus.id_ready       = ready;
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
        @(negedge clk);
        if (rst_n && bus.imem_req && bus.imem_gnt) begin
            int d;
            d = cyc + int'($urandom_range(lat_max, lat_min));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend.push_back('{bus.imem_addr, d});
        end
        @(posedge clk); #1;
        cyc++;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.id_ready = 1'b0;
        pend.delete();
        repeat (2) @(posedge clk);
        #1;
        cyc += 2;
        last_due = cyc;
        rst_n = 1'b1;
    endtask

    // Monitor / scoreboard: expected decode stream is PC-sequential from the last reset/redirect.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_req", bus.imem_req, 0);
                chk("rst_addr", bus.imem_addr, RST_PC);
                chk("rst_valid", bus.if_valid, 0);
                chk("rst_inst", bus.if_inst, NOP_INST);
                chk("rst_pc", bus.if_pc, 0);
`ifdef FETCH_PERF_CNT_EN
                chk("rst_perf_fetched", bus.perf_fetched, 0);
                chk("rst_perf_stall", bus.perf_stall, 0);
`endif
                exp_q.delete();
                nxt_pc = RST_PC; fetch_exp = RST_PC;
                k = 0; inflight = 0; iss_cnt = 0; first_valid_k = -1;
                post_redir = 1'b0; m_fetched = '0; m_stall = '0;
                while (exp_q.size() < 8) begin exp_q.push_back(nxt_pc); nxt_pc += 4; end
                continue;
            end
            if (post_redir) begin
                chk("redir_valid_low", bus.if_valid, 0);
                chk("redir_addr", bus.imem_addr, post_tgt);
            end
            post_redir = 1'b0;
            if (!bus.if_valid) chk("idle_nop", bus.if_inst, NOP_INST);
            if (bus.redirect_valid) chk("req_on_redirect", bus.imem_req, 0);
            if (phase == 1 && first_valid_k < 0 && bus.if_valid) first_valid_k = k;
            if (phase == 1 && k >= 3 && k < 14) chk("p1_stream", bus.if_valid, 1);
`ifdef FETCH_PERF_CNT_EN
            chk("perf_fetched", bus.perf_fetched, m_fetched);
            chk("perf_stall", bus.perf_stall, m_stall);
            if (bus.if_valid && bus.id_ready) m_fetched++;
            if (bus.id_ready && !bus.if_valid && k >= 1) m_stall++;
`endif
            if (bus.imem_req && bus.imem_gnt) begin
                chk("fetch_addr", bus.imem_addr, fetch_exp);
                fetch_exp += 4;
                inflight++;
                iss_cnt++;
            end
            if (bus.imem_rvalid) inflight--;
            chk("credit", 32'(inflight <= QD), 1);
            if (bus.if_valid && bus.id_ready) begin
                e = exp_q.pop_front();
                chk("xfer_pc", bus.if_pc, e);
                chk("xfer_inst", bus.if_inst, mem_word(e));
                xfer_cnt++;
                while (exp_q.size() < 8) begin exp_q.push_back(nxt_pc); nxt_pc += 4; end
            end
            if (bus.redirect_valid) begin
                post_tgt = bus.redirect_pc & 32'hFFFF_FFFC;
                exp_q.delete();
                nxt_pc = post_tgt; fetch_exp = post_tgt;
                while (exp_q.size() < 8) begin exp_q.push_back(nxt_pc); nxt_pc += 4; end
                post_redir = 1'b1;
            end
            k++;
        end
    end

    initial begin
        int x0;
        xfer_cnt = 0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;

        // 1: streaming with 1-cycle memory
        phase = 1;
        do_reset();
        repeat (14) step(1'b1, 1'b0, '0);
        chk("p1_first_valid_cycle", first_valid_k, 3);

        // 2: decode stalled -> exactly QD requests, then drain in order
        phase = 2;
        do_reset();
        repeat (12) step(1'b0, 1'b0, '0);
        chk("p2_issue_count", iss_cnt, QD);
        chk("p2_req_low", bus.imem_req, 0);
        x0 = xfer_cnt;
        repeat (12) step(1'b1, 1'b0, '0);
        chk("p2_drained", 32'(xfer_cnt - x0 >= 4), 1);

        // 3: latency 3, redirect with requests in flight
        phase = 3;
        lat_min = 3; lat_max = 3;
        do_reset();
        for (int i = 0; i < 30 && inflight < 3; i++) step(1'b1, 1'b0, '0);
        chk("p3_inflight_ge3", 32'(inflight >= 3), 1);
        step(1'b1, 1'b1, 32'h100);
        x0 = xfer_cnt;
        repeat (20) step(1'b1, 1'b0, '0);
        chk("p3_progress", 32'(xfer_cnt > x0), 1);

        // 4: unaligned redirect coincident with a transfer
        phase = 4;
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 20 && !bus.if_valid; i++) step(1'b1, 1'b0, '0);
        chk("p4_valid_before_redirect", bus.if_valid, 1);
        x0 = xfer_cnt;
        step(1'b1, 1'b1, 32'h203);
        chk("p4_xfer_at_redirect", xfer_cnt, x0 + 1);
        chk("p4_addr_aligned", bus.imem_addr, 32'h200);
        chk("p4_queue_empty", bus.if_valid, 0);
        repeat (8) step(1'b1, 1'b0, '0);

        // 5: asynchronous reset with a full queue
        phase = 5;
        repeat (10) step(1'b0, 1'b0, '0);
        chk("p5_full_valid", bus.if_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("p5_async_req", bus.imem_req, 0);
        chk("p5_async_valid", bus.if_valid, 0);
        chk("p5_async_inst", bus.if_inst, NOP_INST);
        chk("p5_async_addr", bus.imem_addr, RST_PC);
        do_reset();
        repeat (10) step(1'b1, 1'b0, '0);

        // 6: random traffic, latencies, stalls and redirects
        phase = 6;
        gnt_pct = 70; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 800; i++) begin
            logic rd;
            rd = ($urandom_range(99, 0) < 4);
            step(($urandom_range(99, 0) < 70), rd, rd ? ($urandom & 32'h0000_FFFF) : 32'h0);
        end
        gnt_pct = 100;
        repeat (20) step(1'b1, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
